// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared CPU definitions for the multiply/divide unit.
//   md_op_e    : E-stage multiply/divide-class operation encodings.
//   md_state_e : multiply/divide FSM states.
//   XLEN       : architectural data width of HI/LO and operands.
package md_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Counter start values: 4 multiply cycles, 32 divide steps.
  localparam logic [4:0] MUL_CNT_INIT = 5'd3;
  localparam logic [4:0] DIV_CNT_INIT = 5'd31;

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the E stage and md_unit.
//   start  : operation valid this cycle (master -> slave)
//   md_op  : operation code, see md_op_e (master -> slave)
//   a, b   : rs / rt operands (master -> slave)
//   busy   : operation in progress (slave -> master)
//   done   : one-cycle pulse when HI/LO take a mult/div result (slave -> master)
//   hi, lo : architectural HI/LO registers (slave -> master)
interface md_unit_if;
  import md_unit_pkg::*;

  logic            start;
  logic [2:0]      md_op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, md_op, a, b, input busy, done, hi, lo);
  modport slave  (input start, md_op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit_div_iter.sv
// div_iter: unsigned restoring divider datapath, one quotient bit per step.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load dividend/divisor magnitudes, clear remainder
//   i_step     : perform one shift-subtract step
//   i_dividend : dividend magnitude
//   i_divisor  : divisor magnitude
//   o_quot     : quotient after DATA_W steps
//   o_rem      : remainder after DATA_W steps
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem
);

  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_dvsr;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W:0]   w_diff;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder and quotient bits enter at the LSB.  The remainder is
  // always below the divisor, so a 33-bit difference suffices and its MSB
  // means "trial below divisor, restore".
  assign w_trial = {r_rem, r_quot[DATA_W-1]};
  assign w_diff  = w_trial - {1'b0, r_dvsr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dvsr <= '0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dvsr <= i_divisor;
    end else if (i_step) begin
      if (!w_diff[DATA_W]) begin
        r_rem  <= w_diff[DATA_W-1:0];
        r_quot <= {r_quot[DATA_W-2:0], 1'b1};
      end else begin
        r_rem  <= w_trial[DATA_W-1:0];
        r_quot <= {r_quot[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS-style HI/LO multiply/divide unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : md_unit_if.slave
//              start/md_op/a/b in; busy/done/hi/lo out
// MULT/MULTU take 4 busy cycles, DIV/DIVU take 33 (32 steps plus a sign
// fix-up cycle).  MTHI/MTLO write HI/LO directly from IDLE.  HI/LO change
// only when a whole result is ready; done pulses in the first IDLE cycle.
module md_unit
  import md_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  md_unit_if.slave   bus
);

  md_state_e       r_state;
  md_state_e       w_next;
  logic [4:0]      r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_ma;
  logic [XLEN-1:0] r_mb;
  logic            r_msigned;
  logic            r_neg_q;
  logic            r_neg_r;

  logic w_ld_mul;
  logic w_ld_div;
  logic w_step;
  logic w_dec;
  logic w_wr_mul;
  logic w_wr_fix;
  logic w_wr_mthi;
  logic w_wr_mtlo;

  logic            w_div_signed;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic signed [2*XLEN-1:0] w_ma_x;
  logic signed [2*XLEN-1:0] w_mb_x;
  logic signed [2*XLEN-1:0] w_prod;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                input logic            en);
    return en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and datapath controls
  always_comb begin
    w_next    = r_state;
    w_ld_mul  = 1'b0;
    w_ld_div  = 1'b0;
    w_step    = 1'b0;
    w_dec     = 1'b0;
    w_wr_mul  = 1'b0;
    w_wr_fix  = 1'b0;
    w_wr_mthi = 1'b0;
    w_wr_mtlo = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          case (md_op_e'(bus.md_op))
            OP_MULT, OP_MULTU: begin
              w_ld_mul = 1'b1;
              w_next   = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              w_ld_div = 1'b1;
              w_next   = ST_DIV;
            end
            OP_MTHI: w_wr_mthi = 1'b1;
            OP_MTLO: w_wr_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (r_cnt == 5'd0) begin
          w_wr_mul = 1'b1;
          w_next   = ST_IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DIV: begin
        w_step = 1'b1;
        if (r_cnt == 5'd0) w_next = ST_FIX;
        else               w_dec  = 1'b1;
      end
      ST_FIX: begin
        w_wr_fix = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Divide operands enter the iterator as magnitudes; signs are restored in FIX.
  assign w_div_signed = (bus.md_op == OP_DIV);
  assign w_abs_a      = cond_neg(bus.a, w_div_signed & bus.a[XLEN-1]);
  assign w_abs_b      = cond_neg(bus.b, w_div_signed & bus.b[XLEN-1]);

  div_iter #(.DATA_W(XLEN)) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ld_div),
    .i_step     (w_step),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  // Extending each operand to 64 bits by its signedness makes the low 64 bits
  // of one multiply correct for both MULT and MULTU.
  assign w_ma_x = $signed({{XLEN{r_msigned & r_ma[XLEN-1]}}, r_ma});
  assign w_mb_x = $signed({{XLEN{r_msigned & r_mb[XLEN-1]}}, r_mb});
  assign w_prod = w_ma_x * w_mb_x;

  // Counter, operand latches, HI/LO and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_msigned <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= w_wr_mul | w_wr_fix;

      if (w_ld_mul) begin
        r_ma      <= bus.a;
        r_mb      <= bus.b;
        r_msigned <= (bus.md_op == OP_MULT);
        r_cnt     <= MUL_CNT_INIT;
      end else if (w_ld_div) begin
        // A zero divisor keeps the all-ones quotient un-negated.
        r_neg_q <= w_div_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]) & (bus.b != '0);
        r_neg_r <= w_div_signed & bus.a[XLEN-1];
        r_cnt   <= DIV_CNT_INIT;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 5'd1;
      end

      if (w_wr_mul) begin
        r_hi <= w_prod[2*XLEN-1:XLEN];
        r_lo <= w_prod[XLEN-1:0];
      end else if (w_wr_fix) begin
        r_hi <= cond_neg(w_rem, r_neg_r);
        r_lo <= cond_neg(w_quot, r_neg_q);
      end else begin
        if (w_wr_mthi) r_hi <= bus.a;
        if (w_wr_mtlo) r_lo <= bus.a;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.  The driver pushes the expected
// HI/LO and busy length of each mult/div into a queue; a negedge monitor pops
// and compares on every done pulse and checks HI/LO hold while busy.
module tb_md_unit;
  import md_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_unit_if bus();

  md_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  int          total    = 0;
  int          bad      = 0;
  int          busy_cnt = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] exp_hi   = 32'd0;
  logic [31:0] exp_lo   = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the architectural corner rules.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint          sa, sb, sq, sr, sp;
    longint unsigned up;
    e.lat = (op <= 3'd1) ? 4 : 33;
    e.hi  = 32'd0;
    e.lo  = 32'd0;
    case (op)
      3'd0: begin
        sa = $signed(a); sb = $signed(b); sp = sa * sb;
        e.hi = sp[63:32]; e.lo = sp[31:0];
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32]; e.lo = up[31:0];
      end
      3'd2: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else begin
          sa = $signed(a); sb = $signed(b);
          sq = sa / sb; sr = sa % sb;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: hold check while busy, scoreboard compare on done.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy) begin
        busy_cnt++;
        chk("hold_hi", bus.hi, exp_hi);
        chk("hold_lo", bus.lo, exp_lo);
      end
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result_hi", bus.hi, e.hi);
          chk("result_lo", bus.lo, e.lo);
          chk("busy_cycles", busy_cnt, e.lat);
          exp_hi = e.hi;
          exp_lo = e.lo;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.a = a; bus.b = b;
    if (op <= 3'd3) sb_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
    if (op <= 3'd3) begin
      n = 0;
      while (bus.busy && n < 64) begin
        @(negedge clk);
        n++;
      end
      chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
    end else begin
      if (op == 3'd4) exp_hi = a;
      if (op == 3'd5) exp_lo = a;
      chk("nonbusy_op_busy", {31'd0, bus.busy}, 32'd0);
      chk("nonbusy_op_hi", bus.hi, exp_hi);
      chk("nonbusy_op_lo", bus.lo, exp_lo);
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.md_op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    mon_en = 1'b1;

    // Directed cases
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd7, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFB, 32'd0);
    issue(3'd5, 32'h0000_1234, 32'd0);
    issue(3'd4, 32'hCAFE_0001, 32'd0);
    issue(3'd6, 32'h1111_1111, 32'd5);
    issue(3'd7, 32'h2222_2222, 32'd5);

    // MTHI while a DIV is busy must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd2; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7;
    sb_q.push_back(model(3'd2, 32'hFFFF_FF9C, 32'd7));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd4; bus.a = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int n;
      n = 0;
      while (bus.busy && n < 64) begin
        @(negedge clk);
        n++;
      end
    end
    chk("intrude_idle", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a DIV aborts with HI/LO cleared and no done
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd2; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0; busy_cnt = 0;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", {31'd0, bus.busy}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  E-stage multiply/divide-class instruction valid this cycle.
REQ-005 md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved (no-op).
REQ-006 a  input  32  rs operand.
REQ-007 b  input  32  rt operand.
REQ-008 busy  output  1  operation in progress; consumed by the hazard unit as E_md_signal.
REQ-009 done  output  1  one-cycle pulse when HI/LO take a mult/div result.
REQ-010 hi  output  32  HI register (MFHI source).
REQ-011 lo  output  32  LO register (MFLO source).

Function
REQ-012 States SHALL be IDLE, MUL, DIV, FIX; busy = (state != IDLE), registered.
REQ-013 start is accepted only in IDLE; start while busy SHALL be ignored, with no state, counter or HI/LO change.
REQ-014 MTHI/MTLO in IDLE SHALL write a to hi/lo at the next edge, leave busy at 0, and not pulse done.
REQ-015 MULT/MULTU SHALL latch operands, enter MUL with a 2-bit counter at 3, and decrement once per cycle.
REQ-016 At counter 0 in MUL, {hi,lo} SHALL take the 64-bit signed (MULT) or unsigned (MULTU) product and the state returns to IDLE; busy is high 4 cycles.
REQ-017 DIV/DIVU SHALL latch operand magnitudes (absolute value for DIV) and enter DIV with a 5-bit counter at 31.
REQ-018 DIV performs one restoring shift-subtract step per cycle and moves to FIX after the counter-0 step; busy is high 33 cycles in total.
REQ-019 FIX SHALL negate the quotient when sign(a)^sign(b) for DIV, negate the remainder when sign(a) for DIV, write lo=quotient and hi=remainder, then return to IDLE.
REQ-020 Divide by zero SHALL yield lo=32'hFFFF_FFFF and hi=a, with the full 33-cycle latency.
REQ-021 DIV of 32'h8000_0000 by -1 SHALL yield lo=32'h8000_0000 and hi=0.
REQ-022 done SHALL be high exactly in the first cycle after the HI/LO update (first IDLE cycle), registered.
REQ-023 hi/lo SHALL hold their previous values throughout busy; no partial results are visible.
REQ-024 Reserved md_op with start SHALL be a no-op.

Reset
REQ-025 rst SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear counters and operand registers.
REQ-026 rst during MUL/DIV/FIX SHALL abort the operation with no HI/LO write; rst has priority over start.

Structure
REQ-027 The md_op encodings and state encodings SHALL live in the shared CPU definitions package.
REQ-028 The divider datapath SHALL be one sub-module, div_iter: remainder/quotient registers plus a 33-bit subtractor; md_unit owns the FSM, multiplier and HI/LO.

Verification
REQ-029 MULT a=-3, b=7: busy high 4 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, done for 1 cycle.
REQ-030 MULTU a=b=32'hFFFF_FFFF: hi=32'hFFFF_FFFE, lo=1.
REQ-031 DIV a=-7, b=2: busy high 33 cycles, then lo=-3, hi=-1. DIVU a=7, b=0: lo=32'hFFFF_FFFF, hi=7.
REQ-032 Start DIV, then assert start with MTHI in cycle 10 of busy: the MTHI is ignored and the result is unchanged. MTLO 32'h1234 in IDLE: lo=32'h1234 next cycle, busy stays 0.
REQ-033 rst asserted in cycle 5 of a DIV: next cycle busy=0, hi=lo=0, no done pulse.
